// File: rtl/abr_be_ram_burst_rd.sv
// ---------------------------------------------------------------------------
// abr_be_ram_burst_rd
//
// Turns a single burst request (start address + length-1) into a stream of
// reads against an attached 1R1W byte-enable RAM. Returned words are
// buffered in a 3-entry FIFO and presented as a valid/ready beat stream,
// with rd_last_o marking the final beat of each burst.
//
// Optional feature: define ABR_BURST_RD_ABORT_EN to add the abort_i port.
//
// Parameters:
//   DEPTH        - RAM word count (address wraps DEPTH-1 -> 0)
//   DATA_WIDTH   - RAM word width in bits
//   STROBE_WIDTH - bits per byte lane (must divide DATA_WIDTH)
//
// Ports:
//   clk_i        in   1           clock, rising edge
//   rst_b        in   1           synchronous active-low reset
//   req_valid_i  in   1           burst request valid
//   req_ready_o  out  1           high only when idle
//   req_addr_i   in   ADDR_WIDTH  burst start word address
//   req_len_m1_i in   ADDR_WIDTH  burst length minus one
//   ram_re_o     out  1           RAM read enable
//   ram_raddr_o  out  ADDR_WIDTH  RAM read address
//   ram_rdata_i  in   DATA_WIDTH  RAM read data, one cycle after ram_re_o
//   rd_valid_o   out  1           output beat valid
//   rd_ready_i   in   1           downstream accepts beat
//   rd_data_o    out  DATA_WIDTH  output beat data
//   rd_last_o    out  1           final beat of the burst
//   busy_o       out  1           state is not IDLE
//   abort_i      in   1           (ABR_BURST_RD_ABORT_EN only) drop the burst
// ---------------------------------------------------------------------------
module abr_be_ram_burst_rd #(
  parameter int DEPTH        = 64,
  parameter int DATA_WIDTH   = 32,
  parameter int STROBE_WIDTH = 8,
  localparam int ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_b,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [ADDR_WIDTH-1:0] req_len_m1_i,
  output logic                  ram_re_o,
  output logic [ADDR_WIDTH-1:0] ram_raddr_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_last_o,
  output logic                  busy_o
`ifdef ABR_BURST_RD_ABORT_EN
  ,
  input  logic                  abort_i
`endif
);

  if (DATA_WIDTH % STROBE_WIDTH != 0) begin : g_bad_strobe
    $error("DATA_WIDTH must be a multiple of STROBE_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] iss_cnt;
  logic                  inflight_q;
  logic                  inflight_last_q;

  logic [DATA_WIDTH-1:0] fifo_data [3];
  logic                  fifo_last [3];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [1:0]            count;

  logic                  abort;
  logic [2:0]            credit_used;
  logic                  issue;
  logic                  pop;

`ifdef ABR_BURST_RD_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A read is only issued while buffered plus in-flight words leave a free
  // FIFO slot for its return, so the FIFO can never overflow.
  assign credit_used = {1'b0, count} + {2'b00, inflight_q};
  assign issue       = (state == ISSUE) && (credit_used < 3'd3) && !abort;

  assign ram_re_o    = issue;
  assign ram_raddr_o = addr_q;

  assign rd_valid_o  = (count != 2'd0);
  assign rd_data_o   = rd_valid_o ? fifo_data[rd_ptr] : '0;
  assign rd_last_o   = rd_valid_o && fifo_last[rd_ptr];
  assign pop         = rd_valid_o && rd_ready_i;

  assign req_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);

  // FSM, read issue bookkeeping and the return FIFO. A single in-flight flag
  // suffices because the RAM returns data exactly one cycle after the read;
  // the last-beat marker travels with that flag into the FIFO entry.
  always_ff @(posedge clk_i) begin
    if (!rst_b) begin
      state           <= IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      iss_cnt         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
    end else if (abort) begin
      state           <= IDLE;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= issue && (iss_cnt == len_q);

      if (inflight_q) begin
        fifo_data[wr_ptr] <= ram_rdata_i;
        fifo_last[wr_ptr] <= inflight_last_q;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count + {1'b0, inflight_q} - {1'b0, pop};

      case (state)
        IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            len_q   <= req_len_m1_i;
            iss_cnt <= '0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue) begin
            addr_q  <= (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
            iss_cnt <= iss_cnt + 1'b1;
            if (iss_cnt == len_q) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The last beat is the final word of the burst, so once it is
          // accepted nothing remains in flight or buffered.
          if (pop && rd_last_o) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_abr_be_ram_burst_rd.sv
// ---------------------------------------------------------------------------
// tb_abr_be_ram_burst_rd
//
// Directed bench for abr_be_ram_burst_rd (DEPTH 64, DATA_WIDTH 32). The RAM
// holds 32'hD000_0000 | address, so every expected beat is a hand-written
// constant. Cycle 0 is the cycle in which the request handshake is seen;
// a negedge monitor logs reads, beats and status per cycle.
// Define ABR_BURST_RD_ABORT_EN to also exercise abort_i.
// ---------------------------------------------------------------------------
module tb_abr_be_ram_burst_rd;

  logic        clk_i = 1'b0;
  logic        rst_b = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [5:0]  req_addr_i = '0;
  logic [5:0]  req_len_m1_i = '0;
  logic        ram_re_o;
  logic [5:0]  ram_raddr_o;
  logic [31:0] ram_rdata_i = '0;
  logic        rd_valid_o;
  logic        rd_ready_i = 1'b1;
  logic [31:0] rd_data_o;
  logic        rd_last_o;
  logic        busy_o;
`ifdef ABR_BURST_RD_ABORT_EN
  logic        abort_i = 1'b0;
`endif

  abr_be_ram_burst_rd #(
    .DEPTH(64),
    .DATA_WIDTH(32),
    .STROBE_WIDTH(8)
  ) dut (
    .clk_i(clk_i),
    .rst_b(rst_b),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i),
    .req_len_m1_i(req_len_m1_i),
    .ram_re_o(ram_re_o),
    .ram_raddr_o(ram_raddr_o),
    .ram_rdata_i(ram_rdata_i),
    .rd_valid_o(rd_valid_o),
    .rd_ready_i(rd_ready_i),
    .rd_data_o(rd_data_o),
    .rd_last_o(rd_last_o),
    .busy_o(busy_o)
`ifdef ABR_BURST_RD_ABORT_EN
    ,
    .abort_i(abort_i)
`endif
  );

  always #5 clk_i = ~clk_i;

  // RAM model: one-cycle read latency
  logic [31:0] mem [64];
  always @(posedge clk_i) begin
    if (ram_re_o) ram_rdata_i <= mem[ram_raddr_o];
  end

  int check_count = 0;
  int pass_count  = 0;

  int          cyc = 1000;
  int          re_cyc [$];
  logic [5:0]  re_addr [$];
  logic [31:0] beat_data [$];
  int          beat_cyc [$];
  logic        beat_last [$];
  logic        busy_log [64];
  logic        ready_log [64];
  logic        valid_log [64];
  int          stall_err = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  int          exp_re_cyc [$];
  logic [5:0]  exp_re_addr [$];
  logic [31:0] exp_data [$];
  int          exp_cyc [$];

  // Monitor: samples mid-cycle, well away from the rising edge
  always @(negedge clk_i) begin
    if (req_valid_i && req_ready_o) cyc = 0;
    else cyc = cyc + 1;
    if (cyc < 64) begin
      busy_log[cyc]  = busy_o;
      ready_log[cyc] = req_ready_o;
      valid_log[cyc] = rd_valid_o;
    end
    if (ram_re_o) begin
      re_cyc.push_back(cyc);
      re_addr.push_back(ram_raddr_o);
    end
    if (rd_valid_o && rd_ready_i) begin
      beat_data.push_back(rd_data_o);
      beat_cyc.push_back(cyc);
      beat_last.push_back(rd_last_o);
    end
    if (prev_stall && (!rd_valid_o || rd_data_o !== prev_data)) stall_err++;
    prev_stall = rd_valid_o && !rd_ready_i;
    prev_data  = rd_data_o;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Issue one request; returns at the start of cycle 1
  task automatic applyStimulus(input logic [5:0] addr, input logic [5:0] len_m1);
    re_cyc.delete(); re_addr.delete();
    beat_data.delete(); beat_cyc.delete(); beat_last.delete();
    @(posedge clk_i); #1;
    req_valid_i  = 1'b1;
    req_addr_i   = addr;
    req_len_m1_i = len_m1;
    @(posedge clk_i); #1;
    req_valid_i  = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy_o && n < 300) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (busy_o) checkOutput({tag, "_timeout"}, busy_o, 1'b0);
    repeat (2) @(negedge clk_i);
  endtask

  task automatic checkBurst(input string tag, input int last_idx);
    checkOutput({tag, "_nreads"}, re_cyc.size(), exp_re_cyc.size());
    for (int i = 0; i < exp_re_cyc.size(); i++) begin
      if (i < re_cyc.size()) begin
        checkOutput($sformatf("%s_re_cyc%0d", tag, i), re_cyc[i], exp_re_cyc[i]);
        checkOutput($sformatf("%s_re_addr%0d", tag, i), re_addr[i], exp_re_addr[i]);
      end
    end
    checkOutput({tag, "_nbeats"}, beat_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size(); i++) begin
      if (i < beat_data.size()) begin
        checkOutput($sformatf("%s_data%0d", tag, i), beat_data[i], exp_data[i]);
        checkOutput($sformatf("%s_cyc%0d", tag, i), beat_cyc[i], exp_cyc[i]);
        checkOutput($sformatf("%s_last%0d", tag, i), beat_last[i], (i == last_idx));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hD000_0000 | i;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1 rst_b = 1'b1;
    @(negedge clk_i);
    checkOutput("rst_req_ready", req_ready_o, 1);
    checkOutput("rst_ram_re", ram_re_o, 0);
    checkOutput("rst_ram_raddr", ram_raddr_o, 0);
    checkOutput("rst_rd_valid", rd_valid_o, 0);
    checkOutput("rst_rd_data", rd_data_o, 0);
    checkOutput("rst_rd_last", rd_last_o, 0);
    checkOutput("rst_busy", busy_o, 0);

    // Basic 4-word burst from address 5
    $display("[TB] burst addr 5 len_m1 3");
    exp_re_cyc = '{1, 2, 3, 4};
    exp_re_addr = '{6'd5, 6'd6, 6'd7, 6'd8};
    exp_data = '{32'hD000_0005, 32'hD000_0006, 32'hD000_0007, 32'hD000_0008};
    exp_cyc = '{3, 4, 5, 6};
    applyStimulus(6'd5, 6'd3);
    waitIdle("basic");
    checkBurst("basic", 3);
    checkOutput("basic_busy6", busy_log[6], 1);
    checkOutput("basic_busy7", busy_log[7], 0);

    // Address wrap at DEPTH-1
    $display("[TB] burst addr 62 len_m1 3 (wrap)");
    exp_re_addr = '{6'd62, 6'd63, 6'd0, 6'd1};
    exp_data = '{32'hD000_003E, 32'hD000_003F, 32'hD000_0000, 32'hD000_0001};
    applyStimulus(6'd62, 6'd3);
    waitIdle("wrap");
    checkBurst("wrap", 3);

    // Back-pressure: rd_ready_i low for cycles 3..10
    $display("[TB] burst addr 10 len_m1 7 with stall");
    exp_re_cyc = '{1, 2, 3, 12, 13, 14, 15, 16};
    exp_re_addr = '{6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17};
    exp_data = '{32'hD000_000A, 32'hD000_000B, 32'hD000_000C, 32'hD000_000D,
                 32'hD000_000E, 32'hD000_000F, 32'hD000_0010, 32'hD000_0011};
    exp_cyc = '{11, 12, 13, 14, 15, 16, 17, 18};
    stall_err = 0;
    applyStimulus(6'd10, 6'd7);
    repeat (2) @(posedge clk_i);
    #1 rd_ready_i = 1'b0;
    repeat (8) @(posedge clk_i);
    #1 rd_ready_i = 1'b1;
    waitIdle("stall");
    checkBurst("stall", 7);
    checkOutput("stall_valid_held", valid_log[8], 1);
    checkOutput("stall_data_stable", stall_err, 0);

    // Single-word burst
    $display("[TB] burst addr 20 len_m1 0");
    exp_re_cyc = '{1};
    exp_re_addr = '{6'd20};
    exp_data = '{32'hD000_0014};
    exp_cyc = '{3};
    applyStimulus(6'd20, 6'd0);
    waitIdle("single");
    checkBurst("single", 0);
    checkOutput("single_busy3", busy_log[3], 1);
    checkOutput("single_busy4", busy_log[4], 0);
    checkOutput("single_ready4", ready_log[4], 1);

    // Reset during beat 2, then a fresh burst must carry only its own data
    $display("[TB] reset mid-burst");
    applyStimulus(6'd30, 6'd5);
    repeat (4) @(posedge clk_i);
    #1 rst_b = 1'b0;
    @(posedge clk_i);
    #1 rst_b = 1'b1;
    @(negedge clk_i);
    checkOutput("midrst_valid", rd_valid_o, 0);
    checkOutput("midrst_busy", busy_o, 0);
    repeat (3) @(posedge clk_i);
    exp_re_cyc = '{1, 2};
    exp_re_addr = '{6'd40, 6'd41};
    exp_data = '{32'hD000_0028, 32'hD000_0029};
    exp_cyc = '{3, 4};
    applyStimulus(6'd40, 6'd1);
    waitIdle("postrst");
    checkBurst("postrst", 1);

`ifdef ABR_BURST_RD_ABORT_EN
    // Abort at cycle 4 of a 10-word burst
    $display("[TB] abort mid-burst");
    applyStimulus(6'd50, 6'd9);
    repeat (3) @(posedge clk_i);
    #1 abort_i = 1'b1;
    @(posedge clk_i);
    #1 abort_i = 1'b0;
    @(negedge clk_i);
    checkOutput("abort_valid", rd_valid_o, 0);
    checkOutput("abort_busy", busy_o, 0);
    checkOutput("abort_ready", req_ready_o, 1);
    checkOutput("abort_no_last", beat_last.size() > 0 ? beat_last[beat_last.size()-1] : 1'b0, 0);
    repeat (3) @(posedge clk_i);
    exp_re_cyc = '{1, 2};
    exp_re_addr = '{6'd0, 6'd1};
    exp_data = '{32'hD000_0000, 32'hD000_0001};
    exp_cyc = '{3, 4};
    applyStimulus(6'd0, 6'd1);
    waitIdle("postabort");
    checkBurst("postabort", 1);
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
